// File: rtl/lea_pkg.sv
// LEA key schedule shared definitions: key-length modes, FSM states, schedule constants and
// small 32-bit helpers used by the round logic and the expander top.
package lea_pkg;

   typedef enum logic [1:0] {
      Mode128 = 2'b00,
      Mode192 = 2'b01,
      Mode256 = 2'b10,
      ModeBad = 2'b11
   } lea_mode_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StLoad = 2'b01,
      StGen  = 2'b10,
      StDone = 2'b11
   } ks_state_e;

   localparam logic [31:0] DELTA [8] = '{
      32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
      32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
   };

   localparam logic [4:0] ROT [6] = '{5'd1, 5'd3, 5'd6, 5'd11, 5'd13, 5'd17};

   function automatic logic [5:0] rounds_for(input lea_mode_e m);
      case (m)
         Mode128: return 6'd24;
         Mode192: return 6'd28;
         Mode256: return 6'd32;
         default: return 6'd0;
      endcase
   endfunction

   function automatic logic [3:0] nk_for(input lea_mode_e m);
      case (m)
         Mode128: return 4'd4;
         Mode192: return 4'd6;
         Mode256: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   // A mode is usable only if its key fits in the synthesised key width.
   function automatic logic mode_legal(input lea_mode_e m, input int unsigned max_len);
      case (m)
         Mode128: return max_len >= 128;
         Mode192: return max_len >= 192;
         Mode256: return max_len >= 256;
         default: return 1'b0;
      endcase
   endfunction

   // Shift by (32 - 0) yields zero, so s == 0 returns x unchanged.
   function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (6'd32 - {1'b0, s}));
   endfunction

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/lea_ks_round.sv
// One LEA key schedule round, purely combinational.
//   t_i     : current T[0..7] (unused words ignored for 128/192)
//   round_i : round index i
//   mode_i  : key-length mode
//   t_o     : updated T[0..7]
//   rk_o    : round key RK_i, first word in [191:160]
module lea_ks_round
   import lea_pkg::*;
(
   input  logic [7:0][31:0] t_i,
   input  logic [4:0]       round_i,
   input  lea_mode_e        mode_i,
   output logic [7:0][31:0] t_o,
   output logic [191:0]     rk_o
);

   logic [31:0] d;
   logic [2:0]  base;

   // Delta word index is i mod Nk; for 256 the six touched words start at 6i mod 8.
   always_comb begin
      d    = DELTA[3'(round_i % 5'd6)];
      base = 3'(32'(round_i) * 6);
      case (mode_i)
         Mode128: d = DELTA[{1'b0, round_i[1:0]}];
         Mode256: d = DELTA[round_i[2:0]];
         default: ;
      endcase
   end

   always_comb begin
      t_o  = t_i;
      rk_o = '0;
      case (mode_i)
         Mode128: begin
            for (int j = 0; j < 4; j++) begin
               t_o[j] = rol32(t_i[j] + rol32(d, 5'(32'(round_i) + j)), ROT[j]);
            end
            rk_o = {t_o[0], t_o[1], t_o[2], t_o[1], t_o[3], t_o[1]};
         end
         Mode192: begin
            for (int j = 0; j < 6; j++) begin
               t_o[j] = rol32(t_i[j] + rol32(d, 5'(32'(round_i) + j)), ROT[j]);
            end
            rk_o = {t_o[0], t_o[1], t_o[2], t_o[3], t_o[4], t_o[5]};
         end
         Mode256: begin
            for (int j = 0; j < 6; j++) begin
               t_o[3'(32'(base) + j)] =
                  rol32(t_i[3'(32'(base) + j)] + rol32(d, 5'(32'(round_i) + j)), ROT[j]);
            end
            for (int j = 0; j < 6; j++) begin
               rk_o[32*(5-j) +: 32] = t_o[3'(32'(base) + j)];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lea_key_expander.sv
// LEA-128/192/256 key expander with start/busy/done handshake and a round-key store.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request expansion (honoured only in IDLE)
//   key_len_sel  : 00=128, 01=192, 10=256, 11=illegal
//   key_i        : key, word w at [32w+31:32w] in byte-stream order
//   busy/done/err: handshake; done and err are one-cycle pulses
//   rk_valid     : store holds a complete schedule for num_rounds
//   num_rounds   : 24/28/32 for the latched mode
//   rk_raddr     : store read address; rk_rdata one cycle later
module lea_key_expander
   import lea_pkg::*;
#(
   parameter int unsigned MAX_KEY_LEN = 256,
   parameter int unsigned RK_DEPTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             key_len_sel,
   input  logic [MAX_KEY_LEN-1:0] key_i,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   rk_valid,
   output logic [5:0]             num_rounds,
   input  logic [4:0]             rk_raddr,
   output logic [191:0]           rk_rdata
);

   localparam int unsigned NkMax = MAX_KEY_LEN / 32;
   // Read address is 5 bits wide, so the store is at most 32 entries.
   localparam int unsigned AW    = (RK_DEPTH > 1) ? $clog2(RK_DEPTH) : 1;

   ks_state_e state_q, state_d;

   logic                   accept, reject, last_round;
   lea_mode_e              mode_q;
   logic [MAX_KEY_LEN-1:0] key_q;
   logic [NkMax-1:0][31:0] t_q, t_d;
   logic [7:0][31:0]       t_full, t_nxt;
   logic [191:0]           rk_gen;
   logic [4:0]             round_q, round_d;
   logic                   rk_valid_q, rk_valid_d;
   logic [5:0]             num_rounds_q, num_rounds_d;
   logic                   err_q;
   logic                   store_we;
   logic [191:0]           store_q [RK_DEPTH];
   logic [191:0]           rk_rdata_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign last_round = (state_q == StGen) && ({1'b0, round_q} == num_rounds_q - 6'd1);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (mode_legal(lea_mode_e'(key_len_sel), MAX_KEY_LEN)) begin
                  accept  = 1'b1;
                  state_d = StLoad;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         StLoad:  state_d = StGen;
         StGen:   if (last_round) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StLoad) || (state_q == StGen);
      done = (state_q == StDone);
   end

   // ---------------- control registers ----------------
   always_comb begin
      round_d      = round_q;
      rk_valid_d   = rk_valid_q;
      num_rounds_d = num_rounds_q;
      if (accept) begin
         rk_valid_d   = 1'b0;
         num_rounds_d = rounds_for(lea_mode_e'(key_len_sel));
      end
      if (state_q == StLoad) round_d = '0;
      if (state_q == StGen)  round_d = round_q + 5'd1;
      // Set on the final write so rk_valid rises together with done.
      if (last_round) rk_valid_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         round_q      <= '0;
         rk_valid_q   <= 1'b0;
         num_rounds_q <= '0;
         err_q        <= 1'b0;
      end else begin
         round_q      <= round_d;
         rk_valid_q   <= rk_valid_d;
         num_rounds_q <= num_rounds_d;
         err_q        <= reject;
      end
   end

   assign rk_valid   = rk_valid_q;
   assign num_rounds = num_rounds_q;
   assign err        = err_q;

   // ---------------- datapath ----------------
   always_comb begin
      t_full            = '0;
      t_full[NkMax-1:0] = t_q;
   end

   lea_ks_round u_round (
      .t_i     (t_full),
      .round_i (round_q),
      .mode_i  (mode_q),
      .t_o     (t_nxt),
      .rk_o    (rk_gen)
   );

   always_comb begin
      t_d = t_q;
      case (state_q)
         StLoad: begin
            // Words beyond Nk are loaded too; the round logic ignores them.
            for (int w = 0; w < NkMax; w++) t_d[w] = bswap32(key_q[32*w +: 32]);
         end
         StGen:   t_d = t_nxt[NkMax-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q <= lea_mode_e'(key_len_sel);
         key_q  <= key_i;
      end
      t_q <= t_d;
   end

   // ---------------- round-key store ----------------
   assign store_we = (state_q == StGen) && (32'(round_q) < RK_DEPTH);

   // Not reset; read-before-write gives old data on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (store_we) store_q[round_q[AW-1:0]] <= rk_gen;
      if (32'(rk_raddr) < RK_DEPTH) rk_rdata_q <= store_q[rk_raddr[AW-1:0]];
      else                          rk_rdata_q <= '0;
   end

   assign rk_rdata = rk_rdata_q;

endmodule

// File: tb/tb_lea_key_expander.sv
module tb_lea_key_expander;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start;
   logic [1:0]   key_len_sel;
   logic [255:0] key_i;
   logic         busy, done, err, rk_valid;
   logic [5:0]   num_rounds;
   logic [4:0]   rk_raddr;
   logic [191:0] rk_rdata;

   logic         start2;
   logic [1:0]   sel2;
   logic [127:0] key2;
   logic         busy2, done2, err2, rk_valid2;
   logic [5:0]   num_rounds2;
   logic [4:0]   raddr2;
   logic [191:0] rdata2;

   lea_key_expander #(.MAX_KEY_LEN(256), .RK_DEPTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .key_len_sel(key_len_sel), .key_i(key_i),
      .busy(busy), .done(done), .err(err), .rk_valid(rk_valid), .num_rounds(num_rounds),
      .rk_raddr(rk_raddr), .rk_rdata(rk_rdata)
   );

   lea_key_expander #(.MAX_KEY_LEN(128), .RK_DEPTH(32)) dut128 (
      .clk(clk), .rst(rst), .start(start2), .key_len_sel(sel2), .key_i(key2),
      .busy(busy2), .done(done2), .err(err2), .rk_valid(rk_valid2), .num_rounds(num_rounds2),
      .rk_raddr(raddr2), .rk_rdata(rdata2)
   );

   int checks = 0;
   int failures = 0;
   logic valid_before;

   logic [31:0]  delta_m [8] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
                                32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957};
   int           rot_m [6] = '{1, 3, 6, 11, 13, 17};
   logic [191:0] exp_rk [32];

   typedef struct {
      logic [1:0]   mode;
      logic [255:0] key;
      int           rounds;
      int           lat;
      bit           has_rk0;
      logic [191:0] rk0;
   } vec_t;
   vec_t vecs [3];

   localparam logic [255:0] Key128 = 256'hc3d2e1f0_8796a5b4_4b5a6978_0f1e2d3c;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      logic [63:0] y;
      y = {x, x} << (s % 32);
      return y[63:32];
   endfunction

   function automatic logic [31:0] bsw(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Reference schedule straight from the LEA definition.
   task automatic ref_sched(input logic [1:0] m, input logic [255:0] k);
      logic [31:0]  t [8];
      logic [191:0] rk;
      int nk, nr, idx;
      nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
      nr = (m == 2'b00) ? 24 : (m == 2'b01) ? 28 : 32;
      for (int w = 0; w < 8; w++) t[w] = bsw(k[32*w +: 32]);
      for (int i = 0; i < nr; i++) begin
         if (nk == 8) begin
            for (int j = 0; j < 6; j++) begin
               idx = (6 * i + j) % 8;
               t[idx] = rotl(t[idx] + rotl(delta_m[i % nk], i + j), rot_m[j]);
            end
            rk = '0;
            for (int j = 0; j < 6; j++) rk = {rk[159:0], t[(6 * i + j) % 8]};
         end else begin
            for (int j = 0; j < nk; j++) t[j] = rotl(t[j] + rotl(delta_m[i % nk], i + j), rot_m[j]);
            if (nk == 4) rk = {t[0], t[1], t[2], t[1], t[3], t[1]};
            else         rk = {t[0], t[1], t[2], t[3], t[4], t[5]};
         end
         exp_rk[i] = rk;
      end
   endtask

   task automatic read_cmp(input int a, input logic [191:0] exp, input string name);
      @(negedge clk);
      rk_raddr = 5'(a);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s rk[%0d]", name, a), rk_rdata, exp);
   endtask

   task automatic run(input logic [1:0] m, input logic [255:0] k, input int exp_nr,
                      input int exp_lat, input bit poke, input bit do_reads, input string tag);
      int n, extra;
      bit seen, d_now, err_seen;
      ref_sched(m, k);
      @(negedge clk);
      valid_before = rk_valid;
      start = 1'b1;
      key_len_sel = m;
      key_i = k;
      @(posedge clk);
      n = 0;
      seen = 1'b0;
      err_seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         if (n == 0) begin
            chk({tag, " busy in LOAD"}, 192'(busy), 192'(1));
            chk({tag, " rk_valid cleared"}, 192'(rk_valid), 192'(0));
            chk({tag, " num_rounds"}, 192'(num_rounds), 192'(exp_nr));
            key_i = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
            key_len_sel = 2'b11;
         end
         start = poke && (n == 5);
         if (poke && n == 5) key_i = ~k;
         if (err) err_seen = 1'b1;
         d_now = done;
         @(posedge clk);
         n++;
         if (d_now) seen = 1'b1;
      end
      start = 1'b0;
      chk({tag, " done latency"}, 192'(n), 192'(exp_lat));
      chk({tag, " no err while busy"}, 192'(err_seen), 192'(0));
      if (poke) begin
         extra = 0;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         chk({tag, " single done"}, 192'(extra), 192'(0));
      end
      if (do_reads) begin
         @(negedge clk);
         chk({tag, " rk_valid set"}, 192'(rk_valid), 192'(1));
         chk({tag, " idle after done"}, 192'({busy, done}), 192'(0));
         for (int a = 0; a < exp_nr; a++) read_cmp(a, exp_rk[a], tag);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      logic [255:0] rkey;
      int n;
      bit seen;

      vecs[0] = '{2'b00, Key128, 24, 26, 1'b1,
                  192'h003a0fd4_02497010_194f7db1_02497010_090d0883_02497010};
      vecs[1] = '{2'b01, 256'h0_b4a59687_f0e1d2c3_c3d2e1f0_8796a5b4_4b5a6978_0f1e2d3c,
                  28, 30, 1'b0, 192'h0};
      vecs[2] = '{2'b10, 256'h3c2d1e0f_78695a4b_b4a59687_f0e1d2c3_c3d2e1f0_8796a5b4_4b5a6978_0f1e2d3c,
                  32, 34, 1'b0, 192'h0};

      rst = 1'b1; start = 1'b0; key_len_sel = 2'b00; key_i = '0; rk_raddr = '0;
      start2 = 1'b0; sel2 = 2'b00; key2 = '0; raddr2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", 192'({busy, done, err, rk_valid}), 192'(0));
      chk("reset num_rounds", 192'(num_rounds), 192'(0));
      rst = 1'b0;

      for (int v = 0; v < 3; v++) begin
         run(vecs[v].mode, vecs[v].key, vecs[v].rounds, vecs[v].lat, 1'b0, 1'b1,
             $sformatf("vec%0d", v));
         if (vecs[v].has_rk0) read_cmp(0, vecs[v].rk0, $sformatf("vec%0d golden", v));
      end

      for (int r = 0; r < 6; r++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run(2'(r % 3), rkey, 24 + 4 * (r % 3), 26 + 4 * (r % 3), 1'b0, 1'b1,
             $sformatf("rand%0d", r));
      end

      // Illegal mode 11: rejected, previous schedule stays valid and intact.
      @(negedge clk);
      start = 1'b1; key_len_sel = 2'b11;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("illegal err pulse", 192'(err), 192'(1));
      chk("illegal busy", 192'(busy), 192'(0));
      chk("illegal rk_valid kept", 192'(rk_valid), 192'(1));
      @(negedge clk);
      chk("illegal err one cycle", 192'({err, busy}), 192'(0));
      read_cmp(0, exp_rk[0], "illegal store kept");

      // Second start mid-run with a different key must be ignored.
      run(2'b00, Key128, 24, 26, 1'b1, 1'b1, "poke");

      // Reset in GEN at i=10, then a fresh run.
      @(negedge clk);
      start = 1'b1; key_len_sel = 2'b00; key_i = Key128;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("midrun busy before rst", 192'(busy), 192'(1));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrun rst outputs", 192'({busy, done, rk_valid}), 192'(0));
      chk("midrun rst num_rounds", 192'(num_rounds), 192'(0));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(2'b00, rkey, 24, 26, 1'b0, 1'b1, "after rst");

      // Back-to-back 256 then 128.
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run(2'b10, rkey, 32, 34, 1'b0, 1'b0, "b2b256");
      run(2'b00, Key128, 24, 26, 1'b0, 1'b1, "b2b128");
      chk("b2b rk_valid before accept", 192'(valid_before), 192'(1));

      // 128-only build: complete one run, then mode 10 is rejected.
      @(negedge clk);
      start2 = 1'b1; sel2 = 2'b00; key2 = Key128[127:0];
      @(posedge clk);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         start2 = 1'b0;
         seen = done2;
         @(posedge clk);
         n++;
      end
      chk("dut128 latency", 192'(n), 192'(26));
      @(negedge clk);
      chk("dut128 rk_valid", 192'(rk_valid2), 192'(1));
      start2 = 1'b1; sel2 = 2'b10;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      chk("dut128 mode10 err", 192'(err2), 192'(1));
      chk("dut128 mode10 busy", 192'(busy2), 192'(0));
      chk("dut128 mode10 rk_valid kept", 192'(rk_valid2), 192'(1));
      @(negedge clk);
      chk("dut128 err one cycle", 192'(err2), 192'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lea_key_expander.md
Name: lea_key_expander

Overview:
Run-time configurable LEA key schedule that supports LEA-128, LEA-192 and LEA-256. A start/busy/done handshake replaces the free-running, reset-triggered schedule of the previous generation. It produces one round key per clock into an internal round-key store, and the LEA datapath reads that store through a synchronous read port. It sits between the key register and the LEA encrypt/decrypt round engine, and supplies the round count the engine needs.

Parameters:
- MAX_KEY_LEN, 256, largest key length synthesised (128, 192 or 256). Sets the key port width, the number of T registers (MAX_KEY_LEN/32) and the modes accepted.
- RK_DEPTH, 32, depth of the round-key store. Must be at least the round count of MAX_KEY_LEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new expansion; sampled only in IDLE
- key_len_sel  in  2  00=128, 01=192, 10=256, 11=illegal
- key_i  in  MAX_KEY_LEN  key; word w = key_i[32w+31:32w], in byte-stream order
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when the last round key has been written
- err  out  1  one-cycle pulse when start is rejected
- rk_valid  out  1  the store holds a complete schedule for num_rounds
- num_rounds  out  6  24, 28 or 32, for the latched mode
- rk_raddr  in  5  round-key read address
- rk_rdata  out  192  RK[0] in [191:160] through RK[5] in [31:0]; one-cycle read latency

Behaviour:
- Reset values: busy=0, done=0, err=0, rk_valid=0, num_rounds=0, FSM=IDLE, round counter=0. The contents of the store are not reset.
- States: IDLE, LOAD, GEN, DONE.
- IDLE with start=1 and a legal mode:
  - latch key_len_sel and key_i;
  - clear rk_valid;
  - set num_rounds;
  - go to LOAD.
- A mode is legal only if it is 00, 01 or 10 and its key length is no more than MAX_KEY_LEN.
- IDLE with start=1 and an illegal mode: err=1 for one cycle, state stays IDLE, rk_valid and store unchanged.
- LOAD: T[w] = byteswap(key word w) for w < Nk (Nk = 4, 6 or 8); round counter i=0; busy=1.
- GEN, one round per cycle, with d = DELTA[i mod Nk] and rotation amounts taken mod 32:
  - 128: T[j] = ROL_{R[j]}(T[j] + ROL_{i+j}(d)) for j=0..3; RK_i = {T0,T1,T2,T1,T3,T1}, using the updated T values.
  - 192: same update for j=0..5; RK_i = {T0..T5}.
  - 256: for j=0..5, with idx=(6i+j) mod 8, T[idx] = ROL_{R[j]}(T[idx] + ROL_{i+j}(d)); RK_i = {T[6i mod 8] .. T[(6i+5) mod 8]}.
  - R = {1,3,6,11,13,17}.
  - Write RK_i to store[i] in the same cycle; i increments.
  - When i = num_rounds-1 has been written, go to DONE.
- DONE: done=1 and rk_valid=1 from this cycle; busy=0; next state IDLE.
- Latency: with start sampled at edge k, done is high in cycle k+N+2 (N=num_rounds). For 128 bits that is 26 cycles.
- start while busy is ignored, with no err and no restart.
- key_i and key_len_sel changes after acceptance have no effect.
- Reads are always serviced. While busy, rk_valid=0 and a read returns the entry's current content. Reading store[i] in the cycle it is written returns the old data.
- rst mid-expansion: return to IDLE and clear rk_valid. A partial schedule remains in the store but is flagged invalid.
- Back-to-back: start in the IDLE cycle right after DONE is accepted.

Decomposition:
- Package lea_pkg:
  - DELTA[0:7] = c3efe9db, 44626b02, 79e27c8a, 78df30ec, 715ea49e, c785da0a, e04ef22a, e5c40957;
  - ROT[0:5] = {1,3,6,11,13,17};
  - mode enum;
  - rounds_for(mode), nk_for(mode), rol32() and bswap32() functions.
- Sub-module lea_ks_round: combinational; takes T[0..7], i and mode; returns next T[0..7] and the 192-bit RK_i.
- The top level holds the FSM, T registers, counter and store.

Test Plan:
- 128-bit: key bytes 0f1e2d3c4b5a69788796a5b4c3d2e1f0 (key_i[31:0]=0f1e2d3c), mode 00, start.
  - done occurs 26 cycles after start.
  - Reading address 0 returns 003a0fd4_02497010_194f7db1_02497010_090d0883_02497010.
  - num_rounds=24.
- 192-bit and 256-bit: published LEA vectors. Check RK_0 and RK_last against the golden model, num_rounds=28 and 32, and done at 30 and 34 cycles.
- Illegal mode: key_len_sel=11, and separately 10 with MAX_KEY_LEN=128.
  - err pulses one cycle; busy stays 0; rk_valid is unchanged from its earlier 1.
- Start while busy:
  - a second start at cycle 5 of a 128-bit run is ignored and done comes once, at cycle 26;
  - a key change after acceptance does not alter RK_0.
- Reset mid-run: assert rst in GEN with i=10.
  - rk_valid=0, busy=0, state IDLE;
  - a fresh 128-bit run then completes with correct keys.
- Back-to-back: a 256-bit run followed immediately by a 128-bit run.
  - rk_valid drops on the second accept;
  - entries 0-23 match LEA-128;
  - num_rounds=24.
